// File: rtl/sprite_attr_table_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_attr_table_if
//  Purpose  : Avalon-MM slave bus bundle for the sprite attribute table
//             (select, strobes, word address, write data, read data).
//  Revision : 1.0 - initial release
// ============================================================================
interface sprite_attr_table_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata
  );

  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata
  );
endinterface
`default_nettype wire

// File: rtl/sprite_attr_table.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_attr_table
//  Purpose  : Double-buffered sprite descriptor table. Software writes a
//             staging bank; a commit request copies staging to the active
//             bank at the start of vertical blanking. Provides a frame
//             counter and a sticky commit-done interrupt.
//  Options  : SPRITE_ATTR_READBACK_EN - staging descriptors readable on the bus
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_attr_table #(
  parameter int NUM_SPRITES = 3,
  parameter int VACTIVE     = 480
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  sprite_attr_table_if.slave             bus,
  input  wire logic [9:0]                VGA_VCOUNT,
  output logic      [24*NUM_SPRITES-1:0] sprites,
  output logic                           irq
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  localparam logic [3:0] ADDR_CONTROL = 4'd8;
  localparam logic [3:0] ADDR_STATUS  = 4'd9;
  localparam logic [3:0] ADDR_IRQ_ACK = 4'd10;

  localparam logic [9:0] VACTIVE_C = 10'(VACTIVE);

  logic [1:0]  state_q, state_d;
  logic [9:0]  vcount_q;
  logic [7:0]  frame_q;
  logic        irq_q;
  logic [31:0] readdata_q, readdata_d;
  logic [23:0] staging_q [NUM_SPRITES];
  logic [23:0] active_q  [NUM_SPRITES];

  logic wr_en, rd_en, vb_start, commit_req, irq_ack, pending;
  logic unused_wdata;

  assign wr_en      = bus.chipselect & bus.write;
  assign rd_en      = bus.chipselect & bus.read;
  assign vb_start   = (VGA_VCOUNT == VACTIVE_C) && (vcount_q != VACTIVE_C);
  assign commit_req = wr_en && (bus.address == ADDR_CONTROL) && bus.writedata[0];
  assign irq_ack    = wr_en && (bus.address == ADDR_IRQ_ACK);
  assign pending    = (state_q != S_IDLE);
  assign unused_wdata = &{1'b0, bus.writedata[31:24]};

  // Commit sequencer: requests are only accepted from IDLE, never queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (commit_req) state_d = S_PENDING;
      S_PENDING: if (vb_start)   state_d = S_COMMIT;
      S_COMMIT:                  state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Sequencer state, vblank edge tracking, frame counter and sticky irq (set wins over ack).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      vcount_q <= 10'd0;
      frame_q  <= 8'd0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vcount_q <= VGA_VCOUNT;
      if (vb_start)
        frame_q <= frame_q + 8'd1;
      if (state_q == S_COMMIT)
        irq_q <= 1'b1;
      else if (irq_ack)
        irq_q <= 1'b0;
    end
  end

  generate
    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_desc
      // Staging takes bus writes; active copies the pre-write staging value in COMMIT.
      always_ff @(posedge clk) begin
        if (reset) begin
          staging_q[k] <= 24'd0;
          active_q[k]  <= 24'd0;
        end else begin
          if (wr_en && (bus.address == 4'(k)))
            staging_q[k] <= bus.writedata[23:0];
          if (state_q == S_COMMIT)
            active_q[k] <= staging_q[k];
        end
      end
      assign sprites[24*k +: 24] = active_q[k];
    end
  endgenerate

  // Read mux: STATUS always, staging descriptors only in the readback build.
  always_comb begin
    readdata_d = 32'd0;
    if (bus.address == ADDR_STATUS)
      readdata_d = {16'd0, frame_q, 6'd0, irq_q, pending};
`ifdef SPRITE_ATTR_READBACK_EN
    for (int k = 0; k < NUM_SPRITES; k++) begin
      if (bus.address == 4'(k))
        readdata_d = {8'd0, staging_q[k]};
    end
`else
`endif
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (reset)
      readdata_q <= 32'd0;
    else if (rd_en)
      readdata_q <= readdata_d;
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_attr_table.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_attr_table
//  Purpose  : Self-checking bench for sprite_attr_table with a behavioural
//             reference model of the descriptor banks, frame count and irq.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_attr_table;
  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [9:0]      vc  = 10'd0;
  logic [24*N-1:0] sprites;
  logic            irq;
  int              n_tests = 0;
  int              n_fail  = 0;

  sprite_attr_table_if bus ();

  sprite_attr_table #(.NUM_SPRITES(N), .VACTIVE(480)) dut (
    .clk        (clk),
    .reset      (rst),
    .bus        (bus.slave),
    .VGA_VCOUNT (vc),
    .sprites    (sprites),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: banks, commit phase (0 none, 1 waiting for vblank, 2 copying)
  logic [23:0] m_stage [N];
  logic [23:0] m_active[N];
  int          m_phase;
  logic        m_irq;
  logic [7:0]  m_frames;
  logic [9:0]  m_prev_vc;
  logic [31:0] m_rd;

  function automatic logic [24*N-1:0] exp_sprites();
    logic [24*N-1:0] v;
    for (int k = 0; k < N; k++) v[24*k +: 24] = m_active[k];
    return v;
  endfunction

  // Advance one clock: update the model from pre-edge values, then step the DUT.
  task automatic cycle();
    logic vb;
    logic cs, wr, rd;
    logic [3:0] a;
    logic [31:0] wd;
    cs = bus.chipselect; wr = bus.write; rd = bus.read; a = bus.address; wd = bus.writedata;
    if (rst) begin
      for (int k = 0; k < N; k++) begin m_stage[k] = '0; m_active[k] = '0; end
      m_phase = 0; m_irq = 0; m_frames = 0; m_prev_vc = 0; m_rd = 0;
    end else begin
      vb = (vc == 10'd480) && (m_prev_vc != 10'd480);
      if (cs && rd) begin
        m_rd = 32'd0;
        if (a == 4'd9) m_rd = {16'd0, m_frames, 6'd0, m_irq, (m_phase != 0)};
`ifdef SPRITE_ATTR_READBACK_EN
        if (int'(a) < N) m_rd = {8'd0, m_stage[int'(a)]};
`endif
      end
      if (m_phase == 2) begin
        for (int k = 0; k < N; k++) m_active[k] = m_stage[k];
        m_irq = 1'b1;
      end else if (cs && wr && a == 4'd10) begin
        m_irq = 1'b0;
      end
      if (cs && wr && int'(a) < N) m_stage[int'(a)] = wd[23:0];
      if (m_phase == 2)                                   m_phase = 0;
      else if (m_phase == 1 && vb)                        m_phase = 2;
      else if (m_phase == 0 && cs && wr && a == 4'd8 && wd[0]) m_phase = 1;
      if (vb) m_frames = m_frames + 8'd1;
      m_prev_vc = vc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.chipselect = 0; bus.write = 0; bus.read = 0; bus.address = '0; bus.writedata = '0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.chipselect = 1; bus.write = 1; bus.read = 0; bus.address = a; bus.writedata = d;
    cycle();
    bus_idle();
  endtask

  task automatic bus_read(input logic [3:0] a);
    bus.chipselect = 1; bus.write = 0; bus.read = 1; bus.address = a; bus.writedata = '0;
    cycle();
    bus_idle();
  endtask

  task automatic set_vc(input logic [9:0] v);
    vc = v;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1; cycle(); cycle(); rst = 0;
    n_tests++;
    if (sprites !== '0) begin n_fail++; $display("FAIL reset_sprites: got %h expected 0", sprites); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    bus_read(4'd9);
    n_tests++;
    if (bus.readdata !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", bus.readdata); end
  endtask

  task automatic test_no_commit();
    bus_write(4'd0, 32'h0A0C864);
    set_vc(10'd0); set_vc(10'd479); set_vc(10'd480); set_vc(10'd481); set_vc(10'd0);
    n_tests++;
    if (sprites[23:0] !== 24'd0) begin n_fail++; $display("FAIL nocommit_sprite0: got %h expected 0", sprites[23:0]); end
    bus_read(4'd9);
    n_tests++;
    if (bus.readdata[15:8] !== 8'd1 || bus.readdata !== m_rd) begin
      n_fail++; $display("FAIL nocommit_status: got %h expected %h", bus.readdata, m_rd);
    end
  endtask

  task automatic test_commit();
    vc = 10'd200;
    bus_write(4'd0, 32'h00C864);
    bus_write(4'd8, 32'h1);
    bus_read(4'd9);
    n_tests++;
    if (bus.readdata[0] !== 1'b1) begin n_fail++; $display("FAIL commit_pending: got %b expected 1", bus.readdata[0]); end
    set_vc(10'd479);
    set_vc(10'd480);
    n_tests++;
    if (sprites[23:0] !== 24'd0) begin n_fail++; $display("FAIL commit_early: got %h expected 0", sprites[23:0]); end
    cycle();
    n_tests++;
    if (sprites[23:0] !== 24'h00C864 || irq !== 1'b1) begin
      n_fail++; $display("FAIL commit_load: got sprite0=%h irq=%b expected 00c864/1", sprites[23:0], irq);
    end
    bus_read(4'd9);
    n_tests++;
    if (bus.readdata[0] !== 1'b0) begin n_fail++; $display("FAIL commit_pending_clear: got %b expected 0", bus.readdata[0]); end
    set_vc(10'd0);
  endtask

  task automatic test_commit_collision();
    bus_write(4'd1, 32'h0AAAAA);
    bus_write(4'd8, 32'h1);
    set_vc(10'd479);
    set_vc(10'd480);
    bus_write(4'd1, 32'h123456);
    n_tests++;
    if (sprites[47:24] !== 24'h0AAAAA || irq !== 1'b1) begin
      n_fail++; $display("FAIL collide_old: got sprite1=%h irq=%b expected 0aaaaa/1", sprites[47:24], irq);
    end
    bus_write(4'd10, 32'h0);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ack_clear1: got %b expected 0", irq); end
    bus_write(4'd8, 32'h1);
    set_vc(10'd0);
    set_vc(10'd480);
    bus_write(4'd10, 32'h0);
    n_tests++;
    if (irq !== 1'b1 || sprites[47:24] !== 24'h123456) begin
      n_fail++; $display("FAIL ack_set_wins: got irq=%b sprite1=%h expected 1/123456", irq, sprites[47:24]);
    end
    bus_write(4'd10, 32'h0);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL ack_clear2: got %b expected 0", irq); end
    n_tests++;
    if (sprites !== exp_sprites()) begin n_fail++; $display("FAIL collide_model: got %h expected %h", sprites, exp_sprites()); end
    set_vc(10'd0);
  endtask

  task automatic test_wrap();
    rst = 1; cycle(); rst = 0;
    for (int f = 0; f < 256; f++) begin
      set_vc(10'd479);
      set_vc(10'd480);
    end
    bus_read(4'd9);
    n_tests++;
    if (bus.readdata[15:8] !== 8'd0 || bus.readdata !== m_rd) begin
      n_fail++; $display("FAIL frame_wrap: got %h expected %h", bus.readdata, m_rd);
    end
    bus_write(4'd0, 32'hFF0ABCDE);
    bus_read(4'd0);
    n_tests++;
    if (bus.readdata !== m_rd) begin n_fail++; $display("FAIL readback0: got %h expected %h", bus.readdata, m_rd); end
`ifndef SPRITE_ATTR_READBACK_EN
    n_tests++;
    if (bus.readdata !== 32'd0) begin n_fail++; $display("FAIL readback_off: got %h expected 0", bus.readdata); end
`endif
    bus_read(4'd13);
    n_tests++;
    if (bus.readdata !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", bus.readdata); end
  endtask

  task automatic test_random();
    logic [9:0] vtab [6];
    int errs;
    vtab[0] = 10'd0; vtab[1] = 10'd200; vtab[2] = 10'd479;
    vtab[3] = 10'd480; vtab[4] = 10'd480; vtab[5] = 10'd481;
    errs = 0;
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      rst = (r < 2);
      vc = vtab[$urandom_range(0, 5)];
      bus.chipselect = ($urandom_range(0, 9) != 0);
      bus.write      = 1'b0;
      bus.read       = 1'b0;
      bus.address    = 4'($urandom_range(0, 15));
      bus.writedata  = $urandom;
      case ($urandom_range(0, 5))
        0: begin bus.write = 1; bus.address = 4'($urandom_range(0, N - 1)); end
        1: begin bus.write = 1; bus.address = 4'd8; end
        2: begin bus.write = 1; bus.address = 4'd10; end
        3: begin bus.read = 1; bus.address = 4'd9; end
        4: bus.read = 1;
        default: bus.write = ($urandom_range(0, 1) == 1);
      endcase
      cycle();
      n_tests++;
      if (sprites !== exp_sprites() || irq !== m_irq || bus.readdata !== m_rd) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random_%0d: got spr=%h irq=%b rd=%h expected spr=%h irq=%b rd=%h",
                   i, sprites, irq, bus.readdata, exp_sprites(), m_irq, m_rd);
        errs++;
      end
    end
    rst = 0;
    bus_idle();
  endtask

  initial begin
    bus_idle();
    for (int k = 0; k < N; k++) begin m_stage[k] = '0; m_active[k] = '0; end
    m_phase = 0; m_irq = 0; m_frames = 0; m_prev_vc = 0; m_rd = 0;
    @(negedge clk);
    test_reset();
    test_no_commit();
    test_commit();
    test_commit_collision();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
